// File: rtl/pc16_stack_if.sv
// Bundles the PC-with-return-stack data and control signals between sequencer and PC block.
// Latency: none; signal bundle only.
// Backpressure: none; the master drives controls every cycle and the slave always accepts them.
//
// Ports (master view):
//   in                  load value from the upstream A/ALU mux
//   clr load inc        PC control strobes
//   push pop            return-stack control strobes
//   out                 registered PC value
//   stk_empty stk_full  return-stack occupancy flags
//   err                 sticky overflow/underflow/illegal-op flag
interface pc16_stack_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             clr;
    logic             load;
    logic             inc;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] out;
    logic             stk_empty;
    logic             stk_full;
    logic             err;

    modport master (
        output in, clr, load, inc, push, pop,
        input  out, stk_empty, stk_full, err
    );

    modport slave (
        input  in, clr, load, inc, push, pop,
        output out, stk_empty, stk_full, err
    );
endinterface

// File: rtl/pc16_stack.sv
// Hack-style program counter with a DEPTH-entry LIFO return-address stack.
// Latency: 1 cycle from sampled control to out/flags; out is a pure register output.
// Backpressure: none; illegal or impossible requests (overflow, underflow, push+pop) set sticky err.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   bus (slave modport)  in/clr/load/inc/push/pop in; out/stk_empty/stk_full/err out
module pc16_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pc16_stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] pc_plus1;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_m1;
    logic             err_q;
    logic             err_nxt;
    logic             wr_en;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        pc_plus1 = pc + 1'b1;
        cnt_m1   = cnt - 1'b1;
        empty    = (cnt == '0);
        full     = (cnt == FULL_CNT);
    end

    always_comb begin
        pc_nxt  = pc;
        cnt_nxt = cnt;
        err_nxt = err_q;
        wr_en   = 1'b0;
        if (bus.clr) begin
            pc_nxt  = '0;
            cnt_nxt = '0;
            err_nxt = 1'b0;
        end else if (bus.push && bus.pop) begin
            err_nxt = 1'b1;
        end else if (bus.pop) begin
            if (!empty) begin
                pc_nxt  = mem[cnt_m1[AW-1:0]];
                cnt_nxt = cnt_m1;
            end else begin
                err_nxt = 1'b1;
            end
        end else begin
            if (bus.load) begin
                pc_nxt = bus.in;
            end else if (bus.inc) begin
                pc_nxt = pc_plus1;
            end
            // A push rides along with load/inc/hold; on overflow the PC
            // operation still completes and only the return address is lost.
            if (bus.push) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    // Storage needs no reset: entries at or above cnt are never read.
    // The return address is the pre-edge PC plus one.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt[AW-1:0]] <= pc_plus1;
        end
    end

    assign bus.out       = pc;
    assign bus.stk_empty = empty;
    assign bus.stk_full  = full;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_pc16_stack.sv
// Scoreboard bench for pc16_stack: stimulus queues expected state, monitor compares.
// Latency: expectations are queued 1 ns after the edge that produces them.
// Backpressure: none; the monitor samples every falling edge or on an async-check event.
module tb_pc16_stack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc16_stack_if #(.WIDTH(16)) bus ();

    pc16_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    event chk_ev;

    // Monitor: pops one expectation per falling edge (or immediately on an
    // async check) and compares against the live DUT outputs.
    always begin
        exp_t e;
        @(negedge clk or chk_ev);
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (bus.out !== e.out || bus.stk_empty !== e.empty ||
                bus.stk_full !== e.full || bus.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got out=%h empty=%b full=%b err=%b, expected out=%h empty=%b full=%b err=%b",
                         e.name, bus.out, bus.stk_empty, bus.stk_full, bus.err,
                         e.out, e.empty, e.full, e.err);
            end
        end
    end

    task automatic drive(input logic [15:0] din, input logic c, input logic l,
                         input logic i, input logic pu, input logic po);
        bus.in   = din;
        bus.clr  = c;
        bus.load = l;
        bus.inc  = i;
        bus.push = pu;
        bus.pop  = po;
    endtask

    task automatic expect_now(input string nm, input logic [15:0] eo,
                              input logic ee, input logic ef, input logic er);
        exp_t e;
        e.name  = nm;
        e.out   = eo;
        e.empty = ee;
        e.full  = ef;
        e.err   = er;
        q.push_back(e);
    endtask

    // One clocked operation: controls are c,l,i,pu,po = clr,load,inc,push,pop.
    task automatic step(input string nm, input logic [15:0] din,
                        input logic c, input logic l, input logic i,
                        input logic pu, input logic po,
                        input logic [15:0] eo, input logic ee, input logic ef, input logic er);
        @(negedge clk);
        drive(din, c, l, i, pu, po);
        @(posedge clk);
        #1;
        expect_now(nm, eo, ee, ef, er);
    endtask

    // Drops rst_n between edges with current controls still applied and checks
    // the outputs before any clock edge can occur.
    task automatic async_reset_check(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now(nm, 16'h0000, 1'b1, 1'b0, 1'b0);
        ->chk_ev;
        @(negedge clk);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        expect_now("reset_state", 16'h0000, 1'b1, 1'b0, 1'b0);
        ->chk_ev;
        @(negedge clk);
        rst_n = 1'b1;

        //                 name           in      c  l  i  pu po   out      e  f  err
        // Reset release and increment
        step("inc1",        16'h0000, 0, 0, 1, 0, 0, 16'h0001, 1, 0, 0);
        step("inc2",        16'h0000, 0, 0, 1, 0, 0, 16'h0002, 1, 0, 0);
        step("inc3",        16'h0000, 0, 0, 1, 0, 0, 16'h0003, 1, 0, 0);
        // Load beats increment; wrap
        step("load_vs_inc", 16'h02F3, 0, 1, 1, 0, 0, 16'h02F3, 1, 0, 0);
        step("load_ffff",   16'hFFFF, 0, 1, 0, 0, 0, 16'hFFFF, 1, 0, 0);
        step("inc_wrap",    16'h0000, 0, 0, 1, 0, 0, 16'h0000, 1, 0, 0);
        // Call / return
        step("load_0010",   16'h0010, 0, 1, 0, 0, 0, 16'h0010, 1, 0, 0);
        step("call",        16'h0100, 0, 1, 0, 1, 0, 16'h0100, 0, 0, 0);
        step("call_inc1",   16'h0000, 0, 0, 1, 0, 0, 16'h0101, 0, 0, 0);
        step("call_inc2",   16'h0000, 0, 0, 1, 0, 0, 16'h0102, 0, 0, 0);
        step("ret",         16'h0000, 0, 0, 0, 0, 1, 16'h0011, 1, 0, 0);
        // Fill and overflow
        step("clr0",        16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        step("push_a",      16'h0000, 0, 0, 1, 1, 0, 16'h0001, 0, 0, 0);
        step("push_b",      16'h0000, 0, 0, 1, 1, 0, 16'h0002, 0, 0, 0);
        step("push_c",      16'h0000, 0, 0, 1, 1, 0, 16'h0003, 0, 0, 0);
        step("push_full",   16'h0000, 0, 0, 1, 1, 0, 16'h0004, 0, 1, 0);
        step("push_ovf",    16'h0000, 0, 0, 1, 1, 0, 16'h0005, 0, 1, 1);
        step("pop4",        16'h0000, 0, 0, 0, 0, 1, 16'h0004, 0, 0, 1);
        step("pop3",        16'h0000, 0, 0, 0, 0, 1, 16'h0003, 0, 0, 1);
        step("pop2",        16'h0000, 0, 0, 0, 0, 1, 16'h0002, 0, 0, 1);
        step("pop1",        16'h0000, 0, 0, 0, 0, 1, 16'h0001, 1, 0, 1);
        // Underflow and illegal push+pop
        step("clr1",        16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        step("load_0005",   16'h0005, 0, 1, 0, 0, 0, 16'h0005, 1, 0, 0);
        step("underflow",   16'h0000, 0, 0, 0, 0, 1, 16'h0005, 1, 0, 1);
        step("clr2",        16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        step("call_0040",   16'h0040, 0, 1, 0, 1, 0, 16'h0040, 0, 0, 0);
        step("push_pop",    16'h0077, 0, 1, 1, 1, 1, 16'h0040, 0, 0, 1);
        step("pop_after",   16'h0000, 0, 0, 0, 0, 1, 16'h0001, 1, 0, 1);
        // Clear beats everything
        step("push_d",      16'h0000, 0, 0, 1, 1, 0, 16'h0002, 0, 0, 1);
        step("push_e",      16'h0000, 0, 0, 1, 1, 0, 16'h0003, 0, 0, 1);
        step("clr_prio",    16'h1234, 1, 1, 0, 1, 0, 16'h0000, 1, 0, 0);
        step("pop_cleared", 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 1);
        step("clr3",        16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        // Return address wraps: push at 0xFFFF saves 0x0000
        step("load_ffff2",  16'hFFFF, 0, 1, 0, 0, 0, 16'hFFFF, 1, 0, 0);
        step("call_wrap",   16'h0050, 0, 1, 0, 1, 0, 16'h0050, 0, 0, 0);
        step("ret_wrap",    16'h0000, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 0);
        // Async reset during a pop sequence
        step("call_0200",   16'h0200, 0, 1, 0, 1, 0, 16'h0200, 0, 0, 0);
        step("call_0300",   16'h0300, 0, 1, 0, 1, 0, 16'h0300, 0, 0, 0);
        step("ret_0201",    16'h0000, 0, 0, 0, 0, 1, 16'h0201, 0, 0, 0);
        async_reset_check("async_reset");
        step("inc_post_rst",16'h0000, 0, 0, 1, 0, 0, 16'h0001, 1, 0, 0);

        @(negedge clk);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5 && q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc16_stack.md
# pc16_stack

- 16-bit Hack-style program counter with a small hardware return-address stack.
- Sits directly downstream of the 16-bit two-way mux: the mux output (selecting between A-register value and ALU result) drives `in`.
- Each cycle `out` holds, increments, loads `in`, clears, or pops a saved return address.
- Call/return support comes from a DEPTH-entry LIFO with full/empty flags and a sticky error flag.

## Interface

Parameters:
- `WIDTH`, 16, data/address width.
- `DEPTH`, 4, return-stack entries; power of two, 2..16.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in`  input  WIDTH  load value (from 16-bit mux output).
- `clr`  input  1  synchronous clear of PC, stack and error flag.
- `load`  input  1  load `in` into PC.
- `inc`  input  1  increment PC.
- `push`  input  1  push `out + 1` onto return stack (call).
- `pop`  input  1  load PC from stack top and remove it (return).
- `out`  output  WIDTH  current PC value, registered.
- `stk_empty`  output  1  stack holds 0 entries.
- `stk_full`  output  1  stack holds DEPTH entries.
- `err`  output  1  sticky overflow/underflow/illegal-op flag.

## Operation

Reset (`rst_n` low, asynchronous, takes effect immediately without a clock edge):
- `out` = 0, stack count = 0, `stk_empty` = 1, `stk_full` = 0, `err` = 0.
- Stack storage contents are don't-care.

PC next-value priority per rising edge (highest first):
1. `clr`: `out` ← 0; stack count ← 0; `err` ← 0. All other inputs ignored.
2. `push && pop`: illegal. `out` holds, stack unchanged, `err` ← 1.
3. `pop`:
   - Stack non-empty: `out` ← top entry; count −1.
   - Stack empty: `out` holds, `err` ← 1.
4. `load`: `out` ← `in`.
5. `inc`: `out` ← `out + 1`, modulo 2^WIDTH, so 0xFFFF → 0x0000. No flag on wrap.
6. Otherwise `out` holds.

Push rules (evaluated alongside priorities 4–6; never alongside `clr` or `pop`):
- Pushed value is `out + 1` computed from the current (pre-edge) `out`, modulo 2^WIDTH.
- Stack not full: entry written at index count; count +1.
- Stack full: value discarded, count unchanged, `err` ← 1. The PC operation (load/inc/hold) still completes.
- Typical call is `push && load`: return address saved, PC jumps to `in`.

Flags and error:
- `stk_empty` = (count == 0); `stk_full` = (count == DEPTH). Both registered/derived from registered count, valid in the same cycle as the count.
- `err` is sticky; cleared only by `clr` or reset.
- Stack is strict LIFO; entries beyond count are never visible.

State:
- PC register: WIDTH bits.
- Stack count: $clog2(DEPTH)+1 bits, range 0..DEPTH.
- DEPTH × WIDTH storage array.
- No FSM beyond the count.

## Timing

- All control inputs sampled on rising `clk`; `out`, flags and `err` update on that edge. Latency 1 cycle from control to `out`.
- `out` is a register output, with no combinational path from any input to `out`.
- Pop data is visible on `out` the cycle after `pop` is sampled. Back-to-back pops return entries in reverse push order, one per cycle.
- A push followed next cycle by a pop returns the just-pushed value. No bypass hazard: the write lands at the edge, the read happens at the following edge.
- Reset mid-operation:
  - `rst_n` falling aborts any operation; outputs go to reset values asynchronously.
  - Deassertion is synchronised by the integrating design; the first edge with `rst_n` high performs a normal operation.
- Inputs must be stable around the rising edge; X on control inputs is not handled.

## Test plan

1. **Reset and increment.** Hold `rst_n`=0 mid-cycle, then release and assert `inc` for 3 cycles.
   - During reset: `out`=0x0000, `stk_empty`=1, `err`=0, immediately.
   - After release: `out` reaches 0x0003.
2. **Load versus increment, and wrap.**
   - `in`=0x02F3, `load`=1, `inc`=1 → `out`=0x02F3 next cycle.
   - `in`=0xFFFF, `load`, then `inc` → `out`=0x0000, `err`=0.
3. **Call/return.**
   - `out`=0x0010; `push`+`load` with `in`=0x0100 → `out`=0x0100, `stk_empty`=0.
   - `inc` twice, then `pop` → `out`=0x0011, `stk_empty`=1.
4. **Stack full / overflow.**
   - 4 pushes from `out`=0,1,2,3 via `push`+`inc` → `stk_full`=1.
   - 5th `push`+`inc` → `out` increments, `err`=1, count stays 4.
   - Four pops → `out` = 0x0004, 0x0003, 0x0002, 0x0001 in turn.
5. **Underflow and illegal op.**
   - `pop` on empty stack at `out`=0x0005 → `out` stays 0x0005, `err`=1.
   - After `clr`: `push`+`pop` together → `out` holds, `err`=1, count unchanged.
6. **Clear priority and async reset.**
   - With stack holding 2 entries and `err`=1, assert `clr`+`load`+`push` → `out`=0, `stk_empty`=1, `err`=0.
   - `rst_n` low between edges during a pop sequence → `out`=0 without any clock edge.
